// File: rtl/note_voice.sv
// note_voice -- square-wave voice stage fed by a note sequencer.
//
// Accepts one note per valid/ready handshake (half-period in clocks plus a
// duration in tempo ticks), plays it as a square wave for that many
// i_note_stb ticks, then returns to IDLE to request the next note.
// A period of 0 is a rest: it is timed like a note but stays silent.
//
// Optional feature macro: NOTE_VOICE_ARTIC_EN
//   defined   -> staccato: gate and sample forced silent on the last tick
//                of every note (oscillator keeps running underneath).
//   undefined -> gate held for the whole note duration.
//
// Ports
//   i_clk          system clock
//   i_rst          synchronous reset, active high
//   i_note_stb     tempo tick, single-cycle pulse
//   i_note_valid   note fields valid (held by producer until accepted)
//   o_note_ready   voice can accept a note (registered, high in IDLE)
//   i_note_period  half-period in clocks, 0 = rest
//   i_note_len     duration in ticks, 0 = 2**LEN_W
//   o_gate         note sounding (registered)
//   o_sample       unsigned sample, AMPLITUDE or 0 (registered)
module note_voice #(
    parameter int                  PERIOD_W  = 16,
    parameter int                  LEN_W     = 4,
    parameter int                  SAMPLE_W  = 8,
    parameter logic [SAMPLE_W-1:0] AMPLITUDE = 8'h7F
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_note_stb,
    input  logic                i_note_valid,
    output logic                o_note_ready,
    input  logic [PERIOD_W-1:0] i_note_period,
    input  logic [LEN_W-1:0]    i_note_len,
    output logic                o_gate,
    output logic [SAMPLE_W-1:0] o_sample
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PLAY = 1'b1;

    localparam logic [PERIOD_W-1:0] PERIOD_ONE = PERIOD_W'(1);
    localparam logic [LEN_W:0]      REM_ONE    = (LEN_W + 1)'(1);
    // len==0 encodes the longest note, 2**LEN_W ticks
    localparam logic [LEN_W:0]      REM_FULL   = {1'b1, {LEN_W{1'b0}}};

    logic [0:0]          state_r, state_s;
    logic [PERIOD_W-1:0] period_r, period_s;
    logic [PERIOD_W-1:0] cnt_r, cnt_s;
    logic [LEN_W:0]      rem_r, rem_s;
    logic                phase_r, phase_s;
    logic                ready_r;
    logic                gate_r;
    logic [SAMPLE_W-1:0] sample_r;
    logic                gap_s;
    logic                sounding_s;

    // Articulation gap: last tick of a note is silent only in the staccato build
    always_comb begin
`ifdef NOTE_VOICE_ARTIC_EN
        gap_s = (rem_r == REM_ONE);
`else
        gap_s = 1'b0;
`endif
    end

    // Next-state logic: handshake, tick-based duration and half-period oscillator
    always_comb begin
        state_s  = state_r;
        period_s = period_r;
        cnt_s    = cnt_r;
        rem_s    = rem_r;
        phase_s  = phase_r;
        case (state_r)
            IDLE: begin
                // A strobe in the accept cycle is deliberately not counted
                if (i_note_valid) begin
                    state_s  = PLAY;
                    period_s = i_note_period;
                    rem_s    = (i_note_len == '0) ? REM_FULL : {1'b0, i_note_len};
                    cnt_s    = i_note_period - PERIOD_ONE;
                    phase_s  = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            PLAY: begin
                if (i_note_stb) begin
                    if (rem_r == REM_ONE) begin
                        state_s = IDLE;
                    end else begin
                        rem_s = rem_r - REM_ONE;
                    end
                end else begin
                    rem_s = rem_r;
                end
                // Oscillator runs through the articulation gap; held on rests
                if (period_r != '0) begin
                    if (cnt_r == '0) begin
                        cnt_s   = period_r - PERIOD_ONE;
                        phase_s = ~phase_r;
                    end else begin
                        cnt_s = cnt_r - PERIOD_ONE;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Sounding means playing a pitched note outside the articulation gap
    always_comb begin
        if ((state_r == PLAY) && (period_r != '0) && !gap_s) begin
            sounding_s = 1'b1;
        end else begin
            sounding_s = 1'b0;
        end
    end

    // State and output registers; sample lags phase by one clock
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r  <= IDLE;
            period_r <= '0;
            cnt_r    <= '0;
            rem_r    <= '0;
            phase_r  <= 1'b0;
            ready_r  <= 1'b1;
            gate_r   <= 1'b0;
            sample_r <= '0;
        end else begin
            state_r  <= state_s;
            period_r <= period_s;
            cnt_r    <= cnt_s;
            rem_r    <= rem_s;
            phase_r  <= phase_s;
            ready_r  <= (state_s == IDLE);
            gate_r   <= sounding_s;
            sample_r <= (sounding_s && phase_r) ? AMPLITUDE : '0;
        end
    end

    assign o_note_ready = ready_r;
    assign o_gate       = gate_r;
    assign o_sample     = sample_r;

endmodule
